// File: rtl/green_pkg.sv
// Shared definitions for the green sequencer.
// Holds the opcode class constants, the sequencer FSM state encoding and the
// default datapath/address widths used by green_seq and green_pc.
package green_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  // Instruction class lives in the top nibble of the instruction word.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_BR   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/green_pc.sv
// Program counter for the green sequencer.
// Ports:
//   clk, rst_n  clock and async active-low reset (loads RESET_PC)
//   i_inc       advance PC by one, wrapping at the top of the address space
//   i_load      load i_target (takes priority over i_inc)
//   i_target    branch target
//   o_pc        current PC
module green_pc
  import green_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      // Natural modulo-2^ADDR_W wrap from all-ones back to zero.
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/green_seq.sv
// Instruction sequencer for the green datapath.
// Fetches instruction words, issues them to green as opCode, keeps the A/B
// accumulators and ZNC flags that green consumes, resolves branches and
// generates green's RAM write-enable.
// Ports:
//   clk, rst_n, en        clock, async active-low reset, global enable
//   imem_addr/imem_data   instruction memory (data valid one cycle after addr)
//   opCode, WE            instruction and RAM write-enable to green
//   A_in, B_in, ZNC_in    accumulator/flag state to green
//   A_out, B_out, ZNC_out results from green, captured in WB
//   BR_out                green's branch-taken indication
//   pc, halted            debug PC and halt status
//
// state  | meaning
// FETCH  | present pc on imem_addr
// DECODE | latch instruction; HALT class parks the sequencer
// EXEC   | issue opCode; WE pulses for ST
// WB     | capture green results, select next pc
// HALT   | frozen until reset
module green_seq
  import green_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] opCode,
  output logic [DATA_W-1:0] A_in,
  output logic [DATA_W-1:0] B_in,
  output logic [2:0]        ZNC_in,
  output logic              WE,
  input  logic [DATA_W-1:0] A_out,
  input  logic [DATA_W-1:0] B_out,
  input  logic [2:0]        ZNC_out,
  input  logic              BR_out,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            r_state;
  // Only the parts of ir needed after DECODE are kept: the class nibble and
  // the branch target. The full word goes straight into r_opcode.
  logic [3:0]        r_ir_class;
  logic [ADDR_W-1:0] r_br_tgt;
  logic [DATA_W-1:0] r_opcode;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_znc;
  logic              r_we;
  logic              r_halted;

  logic [3:0]        w_fetch_class;
  logic              w_wb_step;
  logic              w_br_take;
  logic [ADDR_W-1:0] w_pc;

  assign w_fetch_class = imem_data[DATA_W-1 -: 4];
  assign w_wb_step     = en && (r_state == WB);
  // BR_out matters only for a BR instruction in an enabled WB cycle.
  assign w_br_take     = w_wb_step && (r_ir_class == OP_BR) && BR_out;

  green_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_wb_step),
    .i_load   (w_br_take),
    .i_target (r_br_tgt),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_ir_class <= OP_NOP;
      r_br_tgt   <= '0;
      r_opcode   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_znc      <= '0;
      r_we       <= 1'b0;
      r_halted   <= 1'b0;
    end else if (en) begin
      case (r_state)
        FETCH: begin
          r_state <= DECODE;
        end
        DECODE: begin
          r_ir_class <= w_fetch_class;
          r_br_tgt   <= imem_data[ADDR_W-1:0];
          if (w_fetch_class == OP_HALT) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            // opCode/WE are loaded here so they are clean registers for EXEC.
            r_state  <= EXEC;
            r_opcode <= imem_data;
            r_we     <= (w_fetch_class == OP_ST);
          end
        end
        EXEC: begin
          r_state  <= WB;
          r_opcode <= '0;
          r_we     <= 1'b0;
        end
        WB: begin
          r_state <= FETCH;
          r_a     <= A_out;
          r_b     <= B_out;
          r_znc   <= ZNC_out;
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign imem_addr = w_pc;
  assign pc        = w_pc;
  assign opCode    = r_opcode;
  // A stalled EXEC must not write: the RAM sees WE only in the enabled cycle.
  assign WE        = r_we & en;
  assign A_in      = r_a;
  assign B_in      = r_b;
  assign ZNC_in    = r_znc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_green_seq.sv
module tb_green_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] opCode;
  logic [15:0] A_in, B_in;
  logic [2:0]  ZNC_in;
  logic        WE;
  logic [15:0] A_out, B_out;
  logic [2:0]  ZNC_out;
  logic        BR_out;
  logic [7:0]  pc;
  logic        halted;

  green_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .opCode    (opCode),
    .A_in      (A_in),
    .B_in      (B_in),
    .ZNC_in    (ZNC_in),
    .WE        (WE),
    .A_out     (A_out),
    .B_out     (B_out),
    .ZNC_out   (ZNC_out),
    .BR_out    (BR_out),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid one cycle after the address.
  logic [15:0] imem [256];
  always @(posedge clk) imem_data <= imem[imem_addr];

  typedef struct {
    logic [15:0] opc;
    logic        we;
  } iss_t;

  typedef struct {
    string       name;
    logic [7:0]  pc;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  z;
    logic        halted;
    logic        we;
    logic [15:0] opc;
    int          wecnt;
  } snap_t;

  iss_t  iq[$];
  snap_t sq[$];
  event  snap_ev;
  bit    done = 1'b0;
  bit    done_seen = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    we_cnt = 0;

  // Monitor: pops issue expectations whenever green is handed an enabled
  // instruction, and state snapshots whenever the stimulus posts one.
  initial begin
    iss_t  e;
    snap_t s;
    forever begin
      @(negedge clk or snap_ev);
      if (clk === 1'b0 && rst_n === 1'b1) begin
        if (WE === 1'b1) we_cnt++;
        if (opCode !== 16'h0) begin
          checks++;
          if (en !== 1'b1) begin
            if (WE !== 1'b0) begin
              errors++;
              $display("FAIL we_gated_by_en: WE=%b required 0", WE);
            end
          end else if (iq.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: opCode=%h required no issue", opCode);
          end else begin
            e = iq.pop_front();
            if (opCode !== e.opc || WE !== e.we) begin
              errors++;
              $display("FAIL issue: opCode=%h WE=%b required opCode=%h WE=%b",
                       opCode, WE, e.opc, e.we);
            end
          end
        end
      end
      while (sq.size() > 0) begin
        s = sq.pop_front();
        checks++;
        if ({pc, imem_addr, A_in, B_in, ZNC_in, halted, WE, opCode} !==
            {s.pc, s.pc, s.a, s.b, s.z, s.halted, s.we, s.opc} || we_cnt != s.wecnt) begin
          errors++;
          $display("FAIL %s: pc=%h addr=%h A=%h B=%h ZNC=%b halted=%b WE=%b op=%h wecnt=%0d required pc=%h A=%h B=%h ZNC=%b halted=%b WE=%b op=%h wecnt=%0d",
                   s.name, pc, imem_addr, A_in, B_in, ZNC_in, halted, WE, opCode, we_cnt,
                   s.pc, s.a, s.b, s.z, s.halted, s.we, s.opc, s.wecnt);
        end
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        checks++;
        if (iq.size() != 0) begin
          errors++;
          $display("FAIL issue_drain: %0d issues outstanding required 0", iq.size());
        end
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Snapshots are posted only while clk is high so the monitor can tell them
  // apart from its own negedge wakeups.
  task automatic snap(input string n, input logic [7:0] p, input logic [15:0] a,
                      input logic [15:0] b, input logic [2:0] z, input logic h,
                      input logic w, input logic [15:0] o, input int wc);
    sq.push_back('{n, p, a, b, z, h, w, o, wc});
    ->snap_ev;
    #1;
  endtask

  // One full 4-cycle non-ST instruction starting in FETCH.
  task automatic run_instr(input string n, input logic [15:0] opc, input logic br,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] z, input logic [7:0] exp_pc, input int wc);
    if (opc != 16'h0) iq.push_back('{opc, 1'b0});
    A_out   = a;
    B_out   = b;
    ZNC_out = z;
    BR_out  = br;
    clk_n(4);
    snap(n, exp_pc, a, b, z, 1'b0, 1'b0, 16'h0, wc);
  endtask

  task automatic reset_release();
    rst_n = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    A_out   = '0;
    B_out   = '0;
    ZNC_out = '0;
    BR_out  = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

    // Run A: INC, branches (taken / not taken / self-loop), LD, datapath op, wrap.
    imem[8'h00] = 16'h1000;
    imem[8'h01] = 16'h4005;
    imem[8'h05] = 16'h4020;
    imem[8'h06] = 16'h4020;
    imem[8'h20] = 16'h4020;
    imem[8'h21] = 16'h2055;
    imem[8'h22] = 16'h7ABC;
    imem[8'h23] = 16'h40FF;
    imem[8'hFF] = 16'h0000;

    clk_n(1);
    snap("reset", 8'h00, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 16'h0, 0);
    clk_n(1);
    rst_n = 1'b1;

    iq.push_back('{16'h1000, 1'b0});
    A_out = 16'h0001; B_out = 16'h0022; ZNC_out = 3'b010; BR_out = 1'b0;
    clk_n(3);
    snap("inc_in_wb", 8'h00, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 16'h0, 0);
    clk_n(1);
    snap("inc_done", 8'h01, 16'h0001, 16'h0022, 3'b010, 1'b0, 1'b0, 16'h0, 0);

    run_instr("br_taken_5",   16'h4005, 1'b1, 16'h0003, 16'h0044, 3'b001, 8'h05, 0);
    run_instr("br_not_taken", 16'h4020, 1'b0, 16'h0005, 16'h0066, 3'b100, 8'h06, 0);
    run_instr("br_taken_20",  16'h4020, 1'b1, 16'h0007, 16'h0088, 3'b011, 8'h20, 0);
    run_instr("br_self_loop", 16'h4020, 1'b1, 16'h0009, 16'h00AA, 3'b110, 8'h20, 0);
    run_instr("br_loop_exit", 16'h4020, 1'b0, 16'h000B, 16'h00CC, 3'b000, 8'h21, 0);
    run_instr("ld_br_ignored", 16'h2055, 1'b1, 16'hBEEF, 16'h1357, 3'b101, 8'h22, 0);
    run_instr("datapath_op",  16'h7ABC, 1'b0, 16'h0F0F, 16'hF0F0, 3'b100, 8'h23, 0);
    run_instr("br_to_ff",     16'h40FF, 1'b1, 16'h0F0F, 16'hF0F0, 3'b100, 8'hFF, 0);
    run_instr("nop_wrap",     16'h0000, 1'b0, 16'h0F0F, 16'hF0F0, 3'b100, 8'h00, 0);

    // Run B: ST with en dropped for 3 cycles inside EXEC.
    imem[8'h00] = 16'h3000;
    reset_release();
    iq.push_back('{16'h3000, 1'b1});
    A_out = 16'h00AA; B_out = 16'h00BB; ZNC_out = 3'b011; BR_out = 1'b0;
    clk_n(2);
    en = 1'b0;
    clk_n(3);
    snap("st_stalled", 8'h00, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 16'h3000, 0);
    en = 1'b1;
    clk_n(2);
    snap("st_done", 8'h01, 16'h00AA, 16'h00BB, 3'b011, 1'b0, 1'b0, 16'h0, 1);

    // Run C: HALT at address 2, then frozen until reset.
    imem[8'h00] = 16'h1000;
    imem[8'h01] = 16'h0000;
    imem[8'h02] = 16'hF000;
    reset_release();
    run_instr("c_inc", 16'h1000, 1'b0, 16'h0101, 16'h0202, 3'b001, 8'h01, 1);
    run_instr("c_nop", 16'h0000, 1'b0, 16'h0101, 16'h0202, 3'b001, 8'h02, 1);
    clk_n(1);
    snap("halt_decode", 8'h02, 16'h0101, 16'h0202, 3'b001, 1'b0, 1'b0, 16'h0, 1);
    clk_n(1);
    snap("halted", 8'h02, 16'h0101, 16'h0202, 3'b001, 1'b1, 1'b0, 16'h0, 1);
    for (int k = 0; k < 4; k++) begin
      clk_n(5);
      snap("halt_frozen", 8'h02, 16'h0101, 16'h0202, 3'b001, 1'b1, 1'b0, 16'h0, 1);
    end
    rst_n = 1'b0;
    #1;
    snap("halt_reset", 8'h00, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 16'h0, 1);
    clk_n(1);
    rst_n = 1'b1;

    // Run D: async reset in the middle of a ST's EXEC cycle.
    imem[8'h00] = 16'h1000;
    imem[8'h01] = 16'h3000;
    reset_release();
    run_instr("d_inc", 16'h1000, 1'b0, 16'h1234, 16'h5678, 3'b110, 8'h01, 1);
    clk_n(2);
    snap("st_exec", 8'h01, 16'h1234, 16'h5678, 3'b110, 1'b0, 1'b1, 16'h3000, 1);
    #1;
    rst_n = 1'b0;
    #1;
    snap("st_async_reset", 8'h00, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0, 16'h0, 1);
    clk_n(2);

    done = 1'b1;
    ->snap_ev;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
